// File: rtl/nanorv32_datamem_resp.sv
// nanorv32_datamem_resp
// Responder side of the nanorv32 data memory port. A word-organised RAM
// serves CPU read/write requests. Each request completes with a single-cycle
// ready pulse after WAIT_STATES extra cycles. Data out-of-range requests are
// acknowledged but do not touch the RAM, so the CPU can never stall forever.
module nanorv32_datamem_resp #(
    parameter int NANORV32_ADDR_MSB = 31,
    parameter int NANORV32_DATA_MSB = 31,
    parameter int DEPTH             = 1024,
    parameter int WAIT_STATES       = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NANORV32_ADDR_MSB:0]   cpu_datamem_addr,
    input  logic [NANORV32_DATA_MSB:0]   cpu_datamem_wdata,
    input  logic [3:0]                   cpu_datamem_bytesel,
    input  logic                         cpu_datamem_write,
    input  logic                         cpu_datamem_valid,
    output logic [NANORV32_DATA_MSB:0]   datamem_cpu_rdata,
    output logic                         datamem_cpu_ready
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int DW    = NANORV32_DATA_MSB + 1;
    localparam int AW    = NANORV32_ADDR_MSB + 1;

    // Reload value for the wait counter; unused when there are no wait states.
    localparam logic [3:0] WS_M1 =
        (WAIT_STATES > 32'sd0) ? 4'(WAIT_STATES - 32'sd1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [3:0]          cnt_r;
    logic [3:0]          cnt_s;
    logic                enter_resp_s;
    logic                in_range_s;
    logic [IDX_W-1:0]    idx_s;
    logic                we_s;
    logic                rd_done_s;
    logic [DW-1:0]       rdata_r;
    logic                ready_r;
    logic [DW-1:0]       mem_r [DEPTH];

    // The byte offset is irrelevant for a word-organised RAM.
    logic                unused_addr_lsb_s;
    assign unused_addr_lsb_s = ^cpu_datamem_addr[1:0];

    // Address decode: word index and "inside the RAM" flag.
    always_comb begin
        idx_s      = cpu_datamem_addr[IDX_W+1:2];
        in_range_s = ((cpu_datamem_addr >> (IDX_W + 2)) == {AW{1'b0}});
    end

    // Next-state logic of the request sequencer.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        enter_resp_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cpu_datamem_valid) begin
                    if (WAIT_STATES == 32'sd0) begin
                        state_s      = ST_RESP;
                        enter_resp_s = 1'b1;
                    end else begin
                        state_s = ST_WAIT;
                        cnt_s   = WS_M1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!cpu_datamem_valid) begin
                    // CPU withdrew the request: abandon it silently.
                    state_s = ST_IDLE;
                end else if (cnt_r == 4'd0) begin
                    state_s      = ST_RESP;
                    enter_resp_s = 1'b1;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            ST_RESP: begin
                // Always return to IDLE, which guarantees one idle cycle.
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Commit qualifiers; the write is masked during reset so an access that
    // is interrupted by reset never reaches the RAM.
    always_comb begin
        we_s      = enter_resp_s & cpu_datamem_write & in_range_s & rst_n;
        rd_done_s = enter_resp_s & ~cpu_datamem_write;
    end

    // State, wait counter and ready pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            ready_r <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            ready_r <= enter_resp_s;
        end
    end

    // Read data register: updated only when a read completes, else held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_r <= {DW{1'b0}};
        end else if (rd_done_s) begin
            rdata_r <= in_range_s ? mem_r[idx_s] : {DW{1'b0}};
        end else begin
            rdata_r <= rdata_r;
        end
    end

    // RAM byte-lane write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we_s && cpu_datamem_bytesel[i]) begin
                mem_r[idx_s][8*i +: 8] <= cpu_datamem_wdata[8*i +: 8];
            end
        end
    end

    assign datamem_cpu_rdata = rdata_r;
    assign datamem_cpu_ready = ready_r;

endmodule
